inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter: RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 SHALL provide port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: mem_busy  input  1  high = memory stage owns RAM port this cycle; fetch address not serviced.
REQ-005 SHALL provide port: addr_to_memctrl  output  32  byte address of current fetch request.
REQ-006 SHALL provide port: data_from_memctrl  input  8  RAM byte; valid one cycle after an accepted address.
REQ-007 SHALL provide port: jump_en  input  1  PC redirect request (branch/jump taken).
REQ-008 SHALL provide port: jump_addr  input  32  redirect target.
REQ-009 SHALL provide port: id_ready  input  1  decode stage accepts instruction this cycle.
REQ-010 SHALL provide port: inst_valid  output  1  assembled instruction available.
REQ-011 SHALL provide port: inst  output  32  assembled instruction, little-endian.
REQ-012 SHALL provide port: inst_pc  output  32  address of inst.

Function
REQ-013 SHALL implement two states: FETCH (issuing/collecting bytes) and HOLD (presenting instruction).
REQ-014 In FETCH, addr_to_memctrl SHALL equal pc + issue_cnt (issue_cnt 0..3), combinational from registers.
REQ-015 An issue SHALL be accepted when state=FETCH, issue_cnt<4, mem_busy=0; accepted -> issue_cnt increments, pending flag and byte index registered for next cycle.
REQ-016 When mem_busy=1, issue_cnt SHALL hold, address SHALL hold, pending SHALL clear; the following cycle's data_from_memctrl SHALL be ignored.
REQ-017 When pending=1, data_from_memctrl SHALL be written to inst[8*idx+7:8*idx] (byte 0 -> bits 7:0) and recv_cnt incremented.
REQ-018 Capture of the 4th byte SHALL move state to HOLD with inst_valid=1 on the next cycle; unstalled latency: 4 issue cycles, inst_valid asserted in the 5th cycle after entering FETCH.
REQ-019 Each mem_busy cycle during issue SHALL add exactly one cycle of latency.
REQ-020 In HOLD, inst, inst_pc, inst_valid SHALL be stable, no issue SHALL occur, addr_to_memctrl SHALL equal pc, mem_busy ignored.
REQ-021 In HOLD with id_ready=1, transfer SHALL occur: pc <= pc+4, counters/pending cleared, state FETCH, inst_valid=0 next cycle.
REQ-022 inst_pc SHALL be loaded with pc when the 4th byte is captured.
REQ-023 jump_en=1 SHALL take priority in any state: pc <= jump_addr, issue_cnt, recv_cnt, pending cleared, state FETCH, inst_valid=0 next cycle.
REQ-024 A byte returning the cycle after jump_en SHALL be discarded.
REQ-025 jump_en and id_ready both high in HOLD: held instruction counts as transferred; pc SHALL take jump_addr, not pc+4.
REQ-026 PC and byte-address arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0; pc+k wraps); no alignment check on jump_addr.

Reset
REQ-027 rst=0 SHALL immediately force: pc=RESET_PC, state=FETCH, issue_cnt=0, recv_cnt=0, pending=0, inst=0, inst_pc=0, inst_valid=0.
REQ-028 Reset asserted mid-fetch SHALL abandon the partial instruction; first issue SHALL occur on the first rising edge after rst returns high.

Verification
REQ-029 RESET_PC=0, RAM[0..3]=13 05 00 00, mem_busy=0, id_ready=1 -> addresses 0,1,2,3 on consecutive cycles; inst_valid in 5th cycle with inst=0x00000513, inst_pc=0; next address 4.
REQ-030 mem_busy=1 for 2 cycles while issue_cnt=2 -> addr_to_memctrl held at pc+2, bytes returned during busy ignored, inst correct, inst_valid 2 cycles later than REQ-029.
REQ-031 id_ready=0 for 3 cycles in HOLD -> inst_valid, inst, inst_pc unchanged, no issue; id_ready=1 -> next fetch starts at pc+4.
REQ-032 jump_en=1, jump_addr=0x100 while byte 2 pending -> pending byte discarded, addresses 0x100..0x103 issued, inst_pc=0x100, inst from RAM[0x100..0x103].
REQ-033 pc=0xFFFFFFFC, transfer with id_ready=1 -> next addresses 0x0,0x1,0x2,0x3; also jump_addr=0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-034 rst=0 pulse during issue_cnt=3 -> inst_valid=0 and pc=RESET_PC without waiting for clk; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Byte-serial instruction fetch unit. Memory returns one byte per accepted
// address. Four consecutive bytes are assembled little-endian into a 32-bit
// instruction. The instruction is then held until the decode stage takes it.
//
// Ports
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   mem_busy          in   memory stage owns the RAM port; no issue this cycle
//   addr_to_memctrl   out  byte address of the current fetch request
//   data_from_memctrl in   RAM byte, valid one cycle after an accepted address
//   jump_en           in   PC redirect request (highest priority)
//   jump_addr         in   redirect target, any alignment
//   id_ready          in   decode accepts the held instruction this cycle
//   inst_valid        out  assembled instruction available
//   inst              out  assembled instruction (byte 0 in bits 7:0)
//   inst_pc           out  address of inst
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_busy,
  output logic [31:0] addr_to_memctrl,
  input  logic [7:0]  data_from_memctrl,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic        pending_q, pending_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        issue_accept;

  // An address is only serviced when we still need bytes, memory is free,
  // and no redirect is about to throw the request away.
  assign issue_accept = (state_q == FETCH) && (issue_cnt_q < 3'd4) &&
                        !mem_busy && !jump_en;

  // While holding, the address parks on pc; while fetching it walks the
  // four byte addresses of the instruction, wrapping modulo 2^32.
  assign addr_to_memctrl = (state_q == HOLD) ? pc_q
                                             : pc_q + {29'b0, issue_cnt_q};

  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  // Next-state logic. A redirect wins over everything, including a pending
  // byte (which is dropped) and a handoff to decode (the held instruction is
  // still considered consumed, but pc follows jump_addr instead of pc+4).
  // pending_d defaults low so a stalled cycle never captures the next byte.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pending_d   = 1'b0;
    idx_d       = idx_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    valid_d     = valid_q;

    if (jump_en) begin
      pc_d        = jump_addr;
      issue_cnt_d = 3'd0;
      recv_cnt_d  = 3'd0;
      state_d     = FETCH;
      valid_d     = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (issue_accept) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
            pending_d   = 1'b1;
            idx_d       = issue_cnt_q[1:0];
          end
          if (pending_q) begin
            inst_d[{idx_q, 3'b000} +: 8] = data_from_memctrl;
            recv_cnt_d = recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'd3) begin
              state_d   = HOLD;
              valid_d   = 1'b1;
              inst_pc_d = pc_q;
            end
          end
        end
        HOLD: begin
          if (id_ready) begin
            pc_d        = pc_q + 32'd4;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            state_d     = FETCH;
            valid_d     = 1'b0;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers. Reset abandons any partial instruction immediately,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      pending_q   <= 1'b0;
      idx_q       <= 2'd0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Drives inst_fetch from a small byte RAM and compares every cycle against a
// transaction-level model: each instruction is a list of four byte addresses
// that must each be presented once while memory is free, followed by one
// cycle of data return, after which the assembled word is held for decode.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_busy;
  logic [31:0] addr_to_memctrl;
  logic [7:0]  data_from_memctrl;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  logic [7:0] memArr [1024];

  // Reference model: current instruction address, the byte addresses still
  // to be presented, whether the last byte is in flight, and whether an
  // instruction is being held.
  logic [31:0] mPc;
  logic [31:0] addrQ [$];
  bit          mArm;
  bit          mValid;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_busy          (mem_busy),
    .addr_to_memctrl   (addr_to_memctrl),
    .data_from_memctrl (data_from_memctrl),
    .jump_en           (jump_en),
    .jump_addr         (jump_addr),
    .id_ready          (id_ready),
    .inst_valid        (inst_valid),
    .inst              (inst),
    .inst_pc           (inst_pc)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memByte(input logic [31:0] a);
    return memArr[a[9:0]];
  endfunction

  function automatic logic [31:0] expInst(input logic [31:0] p);
    return {memByte(p + 32'd3), memByte(p + 32'd2),
            memByte(p + 32'd1), memByte(p)};
  endfunction

  task automatic startInst(input logic [31:0] p);
    mPc = p;
    addrQ.delete();
    for (int k = 0; k < 4; k++) addrQ.push_back(p + k);
    mArm   = 1'b0;
    mValid = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s timeout waiting for model event", tag);
  endtask

  // Outputs are sampled mid-cycle, well away from the rising edge.
  task automatic checkOutput();
    if (mValid) begin
      checkVal("inst_valid_hold", inst_valid, 32'd1);
      checkVal("inst",            inst,       expInst(mPc));
      checkVal("inst_pc",         inst_pc,    mPc);
      checkVal("hold_addr",       addr_to_memctrl, mPc);
    end else begin
      checkVal("inst_valid_fetch", inst_valid, 32'd0);
      if (addrQ.size() > 0)
        checkVal("fetch_addr", addr_to_memctrl, addrQ[0]);
    end
  endtask

  // Advances the model across one rising edge using this cycle's inputs.
  task automatic modelStep();
    if (jump_en) begin
      startInst(jump_addr);
    end else if (mValid) begin
      if (id_ready) startInst(mPc + 32'd4);
    end else if (mArm) begin
      mArm   = 1'b0;
      mValid = 1'b1;
    end else if (!mem_busy) begin
      void'(addrQ.pop_front());
      if (addrQ.size() == 0) mArm = 1'b1;
    end
  endtask

  // One clock cycle: check, advance the model, then play the RAM, which
  // answers an address one cycle later. A byte returned during a busy cycle
  // is deliberately corrupted so that capturing it would be noticed.
  task automatic tick();
    logic [31:0] a;
    logic        b;
    @(negedge clk);
    checkOutput();
    a = addr_to_memctrl;
    b = mem_busy;
    modelStep();
    @(posedge clk);
    #1;
    data_from_memctrl = b ? ~memByte(a) : memByte(a);
  endtask

  task automatic applyStimulus(input logic busy, input logic ready,
                               input logic jmp, input logic [31:0] jaddr);
    mem_busy  = busy;
    id_ready  = ready;
    jump_en   = jmp;
    jump_addr = jaddr;
    tick();
  endtask

  // Pulls reset low between edges and checks that it acts without a clock,
  // then releases it just after the following rising edge.
  task automatic asyncReset();
    rst = 1'b0;
    #2;
    checkVal("rst_valid",   inst_valid,      32'd0);
    checkVal("rst_addr",    addr_to_memctrl, RESET_PC);
    checkVal("rst_inst",    inst,            32'd0);
    checkVal("rst_inst_pc", inst_pc,         32'd0);
    startInst(RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_from_memctrl = 8'($urandom);
  endtask

  task automatic runToFetchStart();
    int n = 0;
    while (!(addrQ.size() == 4 && !mValid && !mArm) && n < 20) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      n++;
    end
    if (n >= 20) timeoutFail("fetch_start");
  endtask

  task automatic waitValid(input logic ready);
    int n = 0;
    while (!mValid && n < 30) begin
      applyStimulus(1'b0, ready, 1'b0, 32'd0);
      n++;
    end
    if (n >= 30) timeoutFail("wait_valid");
  endtask

  initial begin
    logic [31:0] ja;

    for (int i = 0; i < 1024; i++) memArr[i] = 8'($urandom);
    memArr[0] = 8'h13;
    memArr[1] = 8'h05;
    memArr[2] = 8'h00;
    memArr[3] = 8'h00;

    rst               = 1'b0;
    mem_busy          = 1'b0;
    id_ready          = 1'b1;
    jump_en           = 1'b0;
    jump_addr         = 32'd0;
    data_from_memctrl = 8'd0;

    // Reset state, then the basic unstalled fetch of the first instruction.
    #1;
    asyncReset();
    $display("[TB] basic fetch from reset");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("first_valid",   inst_valid, 32'd1);
    checkVal("first_inst",    inst,       32'h0000_0513);
    checkVal("first_inst_pc", inst_pc,    32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("next_addr", addr_to_memctrl, 32'd4);

    // Two busy cycles with two bytes already issued: two extra cycles.
    $display("[TB] memory stall mid-fetch");
    runToFetchStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("stall_not_yet", inst_valid, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("stall_valid", inst_valid, 32'd1);

    // Decode back-pressure holds the instruction steady.
    $display("[TB] decode back-pressure");
    waitValid(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    // Redirect while the third byte is outstanding.
    $display("[TB] jump during fetch");
    runToFetchStart();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    waitValid(1'b0);
    checkVal("jump_inst_pc", inst_pc, 32'h0000_0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    // Address wrap through the top of the 32-bit space.
    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    waitValid(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("wrap_addr", addr_to_memctrl, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    waitValid(1'b1);
    checkVal("wrap_odd_inst_pc", inst_pc, 32'hFFFF_FFFE);

    // Jump and handoff in the same cycle: the jump target wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    checkVal("jump_over_ready", addr_to_memctrl, 32'h0000_0200);

    // Randomised traffic: stalls, back-pressure and occasional redirects.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                       : $urandom;
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0, ja);
    end

    // Reset while the fourth byte is being issued, and again while holding.
    $display("[TB] reset mid-fetch");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    asyncReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    waitValid(1'b0);
    asyncReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
